// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/OPC/ADDR_HI/ADDR_LO/DATA/CHK byte frames from a uart_rx byte
// stream and turns them into single-pixel writes or full-buffer fills on a
// valid/ready framebuffer write port. Dropped frames are flagged and counted.
module uart_cmd_decoder #(
  parameter int ADDR_W       = 16,
  parameter int FB_DEPTH     = 19200,
  parameter int TIMEOUT_CLKS = 400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  output logic              rx_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_HUNT, S_OPC, S_AHI, S_ALO, S_DAT, S_CHK, S_WRITE, S_FILL
  } state_t;

  localparam logic [7:0]        SYNC_BYTE = 8'hA5;
  localparam logic [7:0]        OP_WRITE  = 8'h01;
  localparam logic [7:0]        OP_FILL   = 8'h02;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CLKS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ack;
  logic [7:0]          r_opc;
  logic [15:0]         r_addr;
  logic [7:0]          r_data;
  logic [7:0]          r_xor;
  logic [31:0]         r_tmo;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_done;
  logic                r_err;
  logic [7:0]          r_err_count;

  logic                w_consume;
  logic                w_in_frame;
  logic                w_timeout;
  logic                w_beat;
  logic                w_addr_ok;
  logic                w_drop;
  logic                w_done;

  assign rx_ack     = r_ack;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = (r_state == S_WRITE) || (r_state == S_FILL);
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_count  = r_err_count;

  // Next-state decode: byte intake, checksum/opcode validation, timeout and write completion
  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    w_done       = 1'b0;
    // A byte is never taken while the previous ack is still out, nor while writing
    w_consume    = rx_ready && !r_ack && (r_state != S_WRITE) && (r_state != S_FILL);
    w_in_frame   = (r_state == S_OPC) || (r_state == S_AHI) || (r_state == S_ALO) ||
                   (r_state == S_DAT) || (r_state == S_CHK);
    // A byte arriving on the expiry cycle wins over the timeout
    w_timeout    = w_in_frame && !w_consume && (r_tmo == TMO_LAST);
    w_beat       = r_wr_en && wr_ready;
    w_addr_ok    = (32'(r_addr) < 32'(FB_DEPTH));
    case (r_state)
      S_HUNT: begin
        if (w_consume && !rx_error && (rx_data == SYNC_BYTE)) w_state_next = S_OPC;
      end
      S_OPC, S_AHI, S_ALO, S_DAT: begin
        if (w_consume) begin
          if (rx_error) begin
            w_drop       = 1'b1;
            w_state_next = S_HUNT;
          end else begin
            w_state_next = state_t'(r_state + 3'd1);
          end
        end else if (w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      S_CHK: begin
        if (w_consume) begin
          if (rx_error || (rx_data != r_xor)) begin
            w_drop       = 1'b1;
            w_state_next = S_HUNT;
          end else if ((r_opc == OP_WRITE) && w_addr_ok) begin
            w_state_next = S_WRITE;
          end else if (r_opc == OP_FILL) begin
            w_state_next = S_FILL;
          end else begin
            w_drop       = 1'b1;
            w_state_next = S_HUNT;
          end
        end else if (w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      S_WRITE: begin
        if (w_beat) begin
          w_done       = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      S_FILL: begin
        if (w_beat && (r_wr_addr == LAST_ADDR)) begin
          w_done       = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      default: w_state_next = S_HUNT;
    endcase
  end

  // State register, frame field capture, timeout counter and write-port datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_ack       <= 1'b0;
      r_opc       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_xor       <= '0;
      r_tmo       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_consume;
      r_done  <= w_done;
      r_err   <= w_drop;
      if (w_drop && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;

      if (w_consume || !w_in_frame) r_tmo <= '0;
      else                          r_tmo <= r_tmo + 32'd1;

      if (w_consume) begin
        case (r_state)
          S_OPC: begin r_opc <= rx_data;        r_xor <= rx_data;         end
          S_AHI: begin r_addr[15:8] <= rx_data; r_xor <= r_xor ^ rx_data; end
          S_ALO: begin r_addr[7:0] <= rx_data;  r_xor <= r_xor ^ rx_data; end
          S_DAT: begin r_data <= rx_data;       r_xor <= r_xor ^ rx_data; end
          default: ;
        endcase
      end

      case (r_state)
        S_CHK: begin
          if (w_state_next == S_WRITE) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_W'(r_addr);
            r_wr_data <= r_data;
          end else if (w_state_next == S_FILL) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= r_data;
          end
        end
        S_WRITE: begin
          if (w_beat) r_wr_en <= 1'b0;
        end
        S_FILL: begin
          if (w_beat) begin
            if (r_wr_addr == LAST_ADDR) r_wr_en   <= 1'b0;
            else                        r_wr_addr <= r_wr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder. Instance A uses the default geometry
// (large framebuffer, long timeout); instance B uses FB_DEPTH=16 and
// TIMEOUT_CLKS=100. Both share inputs; sel picks which one is observed.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_error;
  logic        wr_ready;
  logic        sel;
  logic        rdy_mode;

  logic        ack_a, wr_en_a, busy_a, done_a, err_a;
  logic [15:0] wr_addr_a;
  logic [7:0]  wr_data_a, err_count_a;
  logic        ack_b, wr_en_b, busy_b, done_b, err_b;
  logic [15:0] wr_addr_b;
  logic [7:0]  wr_data_b, err_count_b;

  logic        ack, wr_en, busy, done, err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, err_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] q_addr[$];
  logic [7:0]  q_data[$];
  int n_done, n_err, n_both, n_busy_bad, n_unstable;
  logic        prev_stall;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;

  uart_cmd_decoder dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .rx_ack(ack_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready), .busy(busy_a), .frame_done(done_a), .frame_err(err_a),
    .err_count(err_count_a)
  );

  uart_cmd_decoder #(.ADDR_W(16), .FB_DEPTH(16), .TIMEOUT_CLKS(100)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .rx_ack(ack_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready), .busy(busy_b), .frame_done(done_b), .frame_err(err_b),
    .err_count(err_count_b)
  );

  assign ack       = sel ? ack_b       : ack_a;
  assign wr_en     = sel ? wr_en_b     : wr_en_a;
  assign wr_addr   = sel ? wr_addr_b   : wr_addr_a;
  assign wr_data   = sel ? wr_data_b   : wr_data_a;
  assign busy      = sel ? busy_b      : busy_a;
  assign done      = sel ? done_b      : done_a;
  assign err       = sel ? err_b       : err_a;
  assign err_count = sel ? err_count_b : err_count_a;

  always #5 clk = ~clk;

  // wr_ready: constant 1 or toggling each cycle, changed well after posedge
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      wr_ready = rdy_mode ? ~wr_ready : 1'b1;
    end
  end

  // Write-port monitor: samples at negedge, each sample describes the next posedge
  initial begin
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (wr_en && wr_ready) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        $display("write addr=%h data=%h", wr_addr, wr_data);
      end
      if (done) n_done++;
      if (err) n_err++;
      if (done && err) n_both++;
      if (wr_en && !busy) n_busy_bad++;
      if (prev_stall && (!wr_en || wr_addr != prev_addr || wr_data != prev_data)) n_unstable++;
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    n_done = 0; n_err = 0; n_both = 0; n_busy_bad = 0; n_unstable = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; rx_ready = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n;
    rx_data = b; rx_error = e; rx_ready = 1'b1; n = 0;
    @(negedge clk); #1;
    while (ack !== 1'b1 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL byte_ack byte=%h got=%b exp=1", b, ack);
    end
    $display("byte %h err=%b consumed", b, e);
    rx_ready = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b0);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (n_done < target) begin
      bad++;
      $display("FAIL done_wait got=%0d exp=%0d", n_done, target);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0; rdy_mode = 1'b0;
    reset_dut();
    total++; if (wr_en !== 1'b0)      begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    total++; if (ack !== 1'b0)        begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL rst_errcnt got=%h exp=00", err_count); end
    total++; if (wr_addr !== 16'h0)   begin bad++; $display("FAIL rst_addr got=%h exp=0000", wr_addr); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rst_pulses got=%b%b exp=00", done, err);
    end
  endtask

  task automatic test_single_write();
    sel = 1'b0; rdy_mode = 1'b0;
    reset_dut();
    for (int i = 0; i < 5; i++) send_byte(i == 0 ? 8'hA5 : (i == 1 ? 8'h01 : (i == 2 ? 8'h12 : (i == 3 ? 8'h34 : 8'h5A))), 1'b0);
    send_byte(8'h7D, 1'b0);
    // wr_en must already be up in the cycle right after the CHK byte edge
    total++; if (wr_en !== 1'b1 || wr_addr !== 16'h1234) begin
      bad++; $display("FAIL write_latency got=%b/%h exp=1/1234", wr_en, wr_addr);
    end
    wait_done(1);
    idle(3);
    total++; if (q_addr.size() != 1) begin bad++; $display("FAIL write_count got=%0d exp=1", q_addr.size()); end
    else begin
      total++; if (q_addr[0] !== 16'h1234) begin bad++; $display("FAIL write_addr got=%h exp=1234", q_addr[0]); end
      total++; if (q_data[0] !== 8'h5A)    begin bad++; $display("FAIL write_data got=%h exp=5a", q_data[0]); end
    end
    total++; if (n_done != 1)         begin bad++; $display("FAIL write_done got=%0d exp=1", n_done); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL write_errcnt got=%h exp=00", err_count); end
    total++; if (wr_en !== 1'b0)      begin bad++; $display("FAIL write_wr_en_after got=%b exp=0", wr_en); end
  endtask

  task automatic test_bad_checksum();
    sel = 1'b0; rdy_mode = 1'b0;
    reset_dut();
    send_frame(48'hA5_01_12_34_5A_7C);
    idle(5);
    total++; if (q_addr.size() != 0)  begin bad++; $display("FAIL badchk_write got=%0d exp=0", q_addr.size()); end
    total++; if (n_err != 1)          begin bad++; $display("FAIL badchk_err got=%0d exp=1", n_err); end
    total++; if (err_count !== 8'h01) begin bad++; $display("FAIL badchk_errcnt got=%h exp=01", err_count); end
    send_frame(48'hA5_01_00_07_42_44);
    wait_done(1);
    idle(3);
    total++; if (q_addr.size() != 1 || q_addr[0] !== 16'h0007 || q_data[0] !== 8'h42) begin
      bad++; $display("FAIL badchk_recover got=%0d writes exp=1 write 0007/42", q_addr.size());
    end
    total++; if (err_count !== 8'h01) begin bad++; $display("FAIL badchk_errcnt2 got=%h exp=01", err_count); end
  endtask

  task automatic test_fill();
    sel = 1'b1; rdy_mode = 1'b1;
    reset_dut();
    send_frame(48'hA5_02_00_00_FF_FD);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%b exp=1", busy); end
    // Sent mid-fill; must stay pending until the fill has completed
    send_byte(8'h5C, 1'b0);
    total++; if (n_done != 1) begin bad++; $display("FAIL fill_backpressure done=%0d exp=1", n_done); end
    idle(3);
    total++; if (q_addr.size() != 16) begin bad++; $display("FAIL fill_count got=%0d exp=16", q_addr.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (q_addr[i] !== 16'(i) || q_data[i] !== 8'hFF) begin
          bad++; $display("FAIL fill_beat%0d got=%h/%h exp=%h/ff", i, q_addr[i], q_data[i], 16'(i));
        end
      end
    end
    total++; if (n_busy_bad != 0) begin bad++; $display("FAIL fill_busy_gap got=%0d exp=0", n_busy_bad); end
    total++; if (n_unstable != 0) begin bad++; $display("FAIL fill_stable got=%0d exp=0", n_unstable); end
    total++; if (n_done != 1 || n_err != 0) begin
      bad++; $display("FAIL fill_pulses got=%0d/%0d exp=1/0", n_done, n_err);
    end
    rdy_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    sel = 1'b1; rdy_mode = 1'b0;
    reset_dut();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    total++; if (n != 100) begin bad++; $display("FAIL timeout_clks got=%0d exp=100", n); end
    total++; if (err_count !== 8'h01) begin bad++; $display("FAIL timeout_errcnt got=%h exp=01", err_count); end
    idle(2);
    send_frame(48'hA5_01_00_05_33_37);
    wait_done(1);
    idle(3);
    total++; if (q_addr.size() != 1 || q_addr[0] !== 16'h0005 || q_data[0] !== 8'h33) begin
      bad++; $display("FAIL timeout_recover got=%0d writes exp=1 write 0005/33", q_addr.size());
    end
  endtask

  task automatic test_bad_frames();
    sel = 1'b1; rdy_mode = 1'b0;
    reset_dut();
    send_frame(48'hA5_01_00_20_11_30);
    idle(3);
    total++; if (n_err != 1 || q_addr.size() != 0) begin
      bad++; $display("FAIL range_drop got=%0d err/%0d wr exp=1/0", n_err, q_addr.size());
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0); send_byte(8'h11, 1'b1); send_byte(8'h15, 1'b0);
    idle(3);
    total++; if (n_err != 2 || q_addr.size() != 0) begin
      bad++; $display("FAIL rxerr_drop got=%0d err/%0d wr exp=2/0", n_err, q_addr.size());
    end
    total++; if (err_count !== 8'h02) begin bad++; $display("FAIL rxerr_errcnt got=%h exp=02", err_count); end
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hA5, 1'b0);
    idle(5);
    total++; if (n_err != 2) begin bad++; $display("FAIL hunt_noerr got=%0d exp=2", n_err); end
    total++; if (n_both != 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", n_both); end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    int held;
    sel = 1'b1; rdy_mode = 1'b0;
    reset_dut();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h10, 1'b1);
    idle(2);
    total++; if (err_count !== 8'h01) begin bad++; $display("FAIL midfill_pre_errcnt got=%h exp=01", err_count); end
    send_frame(48'hA5_02_00_00_66_64);
    n = 0;
    while (q_addr.size() < 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    held = q_addr.size();
    @(negedge clk); #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL midfill_wr_en got=%b exp=0", wr_en); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL midfill_errcnt got=%h exp=00", err_count); end
    rst = 1'b0;
    idle(20);
    total++; if (q_addr.size() != held) begin
      bad++; $display("FAIL midfill_no_write got=%0d exp=%0d", q_addr.size(), held);
    end
    clear_mon();
    send_frame(48'hA5_01_00_03_77_75);
    wait_done(1);
    idle(3);
    total++; if (q_addr.size() != 1 || q_addr[0] !== 16'h0003 || q_data[0] !== 8'h77) begin
      bad++; $display("FAIL midfill_recover got=%0d writes exp=1 write 0003/77", q_addr.size());
    end
  endtask

  initial begin
    sel = 1'b0; rdy_mode = 1'b0;
    rst = 1'b1; rx_ready = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    clear_mon();
    test_reset();
    test_single_write();
    test_bad_checksum();
    test_fill();
    test_timeout();
    test_bad_frames();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
